// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared state encoding and stats width for hazard_stall_unit.
// Revision    : 1.0
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOAD_STALL = 2'b01,
        FLUSH      = 2'b10
    } hazard_state_t;

    localparam int STATS_W = 16;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_stall_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; synchronous clear.
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Load-use stall / control-flush FSM with zero-latency outputs.
//               Define HAZARD_STALL_STATS_EN to add stall/flush cycle counters.
// Revision    : 1.0
// ============================================================================
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EX_mem_read,
    input  logic [4:0]         EX_reg_rt,
    input  logic [4:0]         ID_reg_rs,
    input  logic [4:0]         ID_reg_rt,
    input  logic               ID_uses_rt,
    input  logic               branch_taken,
    input  logic               jump,
    output logic               PC_write,
    output logic               IF_ID_write,
    output logic               ID_EX_bubble,
    output logic               IF_ID_flush,
    output logic [1:0]         hazard_state
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [STATS_W-1:0] stall_count,
    output logic [STATS_W-1:0] flush_count
`endif
);

    // First stall cycle is spent in IDLE, so the counter holds the remainder.
    localparam logic [2:0] c_LOAD_INIT = 3'(LOAD_STALL_CYCLES - 1);

    hazard_state_t r_state;
    hazard_state_t w_next_state;
    logic [2:0]    r_count;
    logic [2:0]    w_next_count;
    logic          w_load_use;
    logic          w_ctrl;

    assign w_load_use = EX_mem_read && (EX_reg_rt != 5'd0) &&
                        ((EX_reg_rt == ID_reg_rs) ||
                         (ID_uses_rt && (EX_reg_rt == ID_reg_rt)));
    assign w_ctrl     = branch_taken || jump;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        hazard_state = r_state;

        case (r_state)
            IDLE: begin
                w_next_count = 3'd0;
                if (w_ctrl) begin
                    IF_ID_flush  = 1'b1;
                    w_next_state = (BRANCH_FLUSH_CYCLES == 2) ? FLUSH : IDLE;
                end else if (w_load_use) begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                    if (c_LOAD_INIT != 3'd0) begin
                        w_next_state = LOAD_STALL;
                        w_next_count = c_LOAD_INIT;
                    end
                end
            end
            LOAD_STALL: begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
                if (r_count <= 3'd1) begin
                    w_next_state = IDLE;
                    w_next_count = 3'd0;
                end else begin
                    w_next_count = r_count - 3'd1;
                end
            end
            FLUSH: begin
                IF_ID_flush  = 1'b1;
                w_next_state = IDLE;
                w_next_count = 3'd0;
            end
            default: begin
                w_next_state = IDLE;
                w_next_count = 3'd0;
            end
        endcase

        // Reset masks the controls in the same cycle it is asserted.
        if (reset) begin
            PC_write     = 1'b1;
            IF_ID_write  = 1'b1;
            ID_EX_bubble = 1'b0;
            IF_ID_flush  = 1'b0;
            hazard_state = IDLE;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    sat_counter #(
        .WIDTH (STATS_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ID_EX_bubble),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (STATS_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (IF_ID_flush),
        .count (flush_count)
    );
`endif

endmodule : hazard_stall_unit
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Directed bench; d1 uses N=1/B=1, d3 uses N=3/B=2, shared inputs.
// Revision    : 1.0
// ============================================================================
module tb_hazard_stall_unit;

    // Output vectors are {PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, hazard_state}
    localparam logic [5:0] c_IDLE_O  = 6'b110000;
    localparam logic [5:0] c_STALL0  = 6'b001000;
    localparam logic [5:0] c_STALL1  = 6'b001001;
    localparam logic [5:0] c_FLUSH0  = 6'b110100;
    localparam logic [5:0] c_FLUSH2  = 6'b110110;

    logic       clk = 1'b0;
    logic       reset;
    logic       EX_mem_read;
    logic [4:0] EX_reg_rt;
    logic [4:0] ID_reg_rs;
    logic [4:0] ID_reg_rt;
    logic       ID_uses_rt;
    logic       branch_taken;
    logic       jump;

    logic       pc1, ifw1, bub1, fl1;
    logic [1:0] st1;
    logic       pc3, ifw3, bub3, fl3;
    logic [1:0] st3;
    logic [5:0] o1, o3;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] sc1, fc1, sc3, fc3;
`endif

    always #5 clk = ~clk;

    assign o1 = {pc1, ifw1, bub1, fl1, st1};
    assign o3 = {pc3, ifw3, bub3, fl3, st3};

    hazard_stall_unit #(
        .LOAD_STALL_CYCLES   (1),
        .BRANCH_FLUSH_CYCLES (1)
    ) d1 (
        .clk          (clk),
        .reset        (reset),
        .EX_mem_read  (EX_mem_read),
        .EX_reg_rt    (EX_reg_rt),
        .ID_reg_rs    (ID_reg_rs),
        .ID_reg_rt    (ID_reg_rt),
        .ID_uses_rt   (ID_uses_rt),
        .branch_taken (branch_taken),
        .jump         (jump),
        .PC_write     (pc1),
        .IF_ID_write  (ifw1),
        .ID_EX_bubble (bub1),
        .IF_ID_flush  (fl1),
        .hazard_state (st1)
`ifdef HAZARD_STALL_STATS_EN
        ,
        .stall_count  (sc1),
        .flush_count  (fc1)
`endif
    );

    hazard_stall_unit #(
        .LOAD_STALL_CYCLES   (3),
        .BRANCH_FLUSH_CYCLES (2)
    ) d3 (
        .clk          (clk),
        .reset        (reset),
        .EX_mem_read  (EX_mem_read),
        .EX_reg_rt    (EX_reg_rt),
        .ID_reg_rs    (ID_reg_rs),
        .ID_reg_rt    (ID_reg_rt),
        .ID_uses_rt   (ID_uses_rt),
        .branch_taken (branch_taken),
        .jump         (jump),
        .PC_write     (pc3),
        .IF_ID_write  (ifw3),
        .ID_EX_bubble (bub3),
        .IF_ID_flush  (fl3),
        .hazard_state (st3)
`ifdef HAZARD_STALL_STATS_EN
        ,
        .stall_count  (sc3),
        .flush_count  (fc3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        EX_mem_read  = 1'b0;
        EX_reg_rt    = 5'd0;
        ID_reg_rs    = 5'd0;
        ID_reg_rt    = 5'd0;
        ID_uses_rt   = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
    endtask

    task automatic set_load_use();
        EX_mem_read = 1'b1;
        EX_reg_rt   = 5'd5;
        ID_reg_rs   = 5'd5;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        set_load_use();
        branch_taken = 1'b1;
        tick();
        #1;
        total_cnt++;
        if (o1 !== c_IDLE_O) $display("FAIL reset_forced_d1: got %b expected %b", o1, c_IDLE_O);
        else pass_cnt++;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL reset_forced_d3: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL post_reset_idle_d3: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        tick();
        set_load_use();
        #1;
        total_cnt++;
        if (o1 !== c_STALL0) $display("FAIL lu_n1_detect: got %b expected %b", o1, c_STALL0);
        else pass_cnt++;
        total_cnt++;
        if (o3 !== c_STALL0) $display("FAIL lu_n3_c0: got %b expected %b", o3, c_STALL0);
        else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++;
        if (o1 !== c_IDLE_O) $display("FAIL lu_n1_release: got %b expected %b", o1, c_IDLE_O);
        else pass_cnt++;
        total_cnt++;
        if (o3 !== c_STALL1) $display("FAIL lu_n3_c1: got %b expected %b", o3, c_STALL1);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (o3 !== c_STALL1) $display("FAIL lu_n3_c2: got %b expected %b", o3, c_STALL1);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL lu_n3_c3: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
    endtask

    task automatic test_rt_match();
        tick();
        EX_mem_read = 1'b1;
        EX_reg_rt   = 5'd7;
        ID_reg_rs   = 5'd3;
        ID_reg_rt   = 5'd7;
        ID_uses_rt  = 1'b1;
        #1;
        total_cnt++;
        if (o1 !== c_STALL0) $display("FAIL rt_match_stall: got %b expected %b", o1, c_STALL0);
        else pass_cnt++;
        tick();
        clear_inputs();
        tick();
        tick();
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL rt_match_settle_d3: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
    endtask

    task automatic test_no_stall();
        tick();
        EX_mem_read = 1'b1;
        EX_reg_rt   = 5'd0;
        ID_reg_rs   = 5'd0;
        #1;
        total_cnt++;
        if (o1 !== c_IDLE_O) $display("FAIL r0_no_stall: got %b expected %b", o1, c_IDLE_O);
        else pass_cnt++;
        tick();
        EX_reg_rt  = 5'd9;
        ID_reg_rs  = 5'd2;
        ID_reg_rt  = 5'd9;
        ID_uses_rt = 1'b0;
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL rt_unused_no_stall: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
        tick();
        EX_mem_read = 1'b0;
        ID_reg_rs   = 5'd9;
        #1;
        total_cnt++;
        if (o1 !== c_IDLE_O) $display("FAIL not_load_no_stall: got %b expected %b", o1, c_IDLE_O);
        else pass_cnt++;
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        tick();
        set_load_use();
        branch_taken = 1'b1;
        #1;
        total_cnt++;
        if (o1 !== c_FLUSH0) $display("FAIL prio_d1_c0: got %b expected %b", o1, c_FLUSH0);
        else pass_cnt++;
        total_cnt++;
        if (o3 !== c_FLUSH0) $display("FAIL prio_d3_c0: got %b expected %b", o3, c_FLUSH0);
        else pass_cnt++;
        tick();
        branch_taken = 1'b0;
        #1;
        total_cnt++;
        if (o3 !== c_FLUSH2) $display("FAIL prio_d3_flush_ignores_lu: got %b expected %b", o3, c_FLUSH2);
        else pass_cnt++;
        total_cnt++;
        if (o1 !== c_STALL0) $display("FAIL prio_d1_lu_after_flush: got %b expected %b", o1, c_STALL0);
        else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL prio_d3_c2: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
    endtask

    task automatic test_jump();
        tick();
        jump = 1'b1;
        #1;
        total_cnt++;
        if (o1 !== c_FLUSH0) $display("FAIL jump_d1: got %b expected %b", o1, c_FLUSH0);
        else pass_cnt++;
        tick();
        jump = 1'b0;
        #1;
        total_cnt++;
        if (o1 !== c_IDLE_O) $display("FAIL jump_d1_single: got %b expected %b", o1, c_IDLE_O);
        else pass_cnt++;
        total_cnt++;
        if (o3 !== c_FLUSH2) $display("FAIL jump_d3_second: got %b expected %b", o3, c_FLUSH2);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL jump_d3_done: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
    endtask

    task automatic test_ignore_in_stall();
        tick();
        set_load_use();
        tick();
        clear_inputs();
        branch_taken = 1'b1;
        #1;
        total_cnt++;
        if (o3 !== c_STALL1) $display("FAIL stall_ignores_branch: got %b expected %b", o3, c_STALL1);
        else pass_cnt++;
        total_cnt++;
        if (o1 !== c_FLUSH0) $display("FAIL d1_branch_in_idle: got %b expected %b", o1, c_FLUSH0);
        else pass_cnt++;
        tick();
        branch_taken = 1'b0;
        #1;
        total_cnt++;
        if (o3 !== c_STALL1) $display("FAIL stall_last_cycle: got %b expected %b", o3, c_STALL1);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL stall_exit_idle: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        tick();
        set_load_use();
        tick();
        clear_inputs();
        reset = 1'b1;
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL reset_mid_stall_outputs: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL reset_mid_stall_next: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
        tick();
        jump = 1'b1;
        tick();
        jump  = 1'b0;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (o3 !== c_IDLE_O) $display("FAIL reset_mid_flush_outputs: got %b expected %b", o3, c_IDLE_O);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        set_load_use();
        #1;
        total_cnt++;
        if (o3 !== c_STALL0) $display("FAIL post_reset_hazard_eval: got %b expected %b", o3, c_STALL0);
        else pass_cnt++;
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

`ifdef HAZARD_STALL_STATS_EN
    task automatic test_stats();
        tick();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
        set_load_use();
        for (int i = 0; i < 4; i++) tick();
        clear_inputs();
        jump = 1'b1;
        tick();
        jump = 1'b0;
        tick();
        jump = 1'b1;
        tick();
        jump = 1'b0;
        tick();
        total_cnt++;
        if (sc1 !== 16'd4) $display("FAIL stats_stall_count: got %0d expected %0d", sc1, 4);
        else pass_cnt++;
        total_cnt++;
        if (fc1 !== 16'd2) $display("FAIL stats_flush_count: got %0d expected %0d", fc1, 2);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_load_use();
        for (int i = 0; i < 65535; i++) tick();
        clear_inputs();
        total_cnt++;
        if (sc1 !== 16'hFFFF) $display("FAIL stats_preload: got %h expected %h", sc1, 16'hFFFF);
        else pass_cnt++;
        set_load_use();
        tick();
        clear_inputs();
        tick();
        total_cnt++;
        if (sc1 !== 16'hFFFF) $display("FAIL stats_saturate: got %h expected %h", sc1, 16'hFFFF);
        else pass_cnt++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_rt_match();
        test_no_stall();
        test_branch_priority();
        test_jump();
        test_ignore_in_stall();
        test_reset_mid_op();
`ifdef HAZARD_STALL_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_hazard_stall_unit
`default_nettype wire
